// File: rtl/hsv_frame_receiver.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// hsv_frame_receiver
//
// Receives bit-serial HSV pixels clocked by a Raspberry Pi over GPIO. The Pi
// clock, data and enable lines are synchronised and the Pi clock debounced in
// the fpga_clk domain. Each pixel is thresholded into a hand/non-hand mask bit
// and stored into a LENGTH x WIDTH frame buffer that is read out by row.
//
// Ports
//   fpga_clk      system clock
//   rst           asynchronous active-high reset
//   pi_clk        Pi serial clock (asynchronous)
//   data_in       Pi serial data, LSB first (asynchronous)
//   write_enable  Pi transfer enable; low pauses the transfer (asynchronous)
//   min_hue       hue lower bound, inclusive
//   max_hue       hue upper bound, inclusive (min_hue > max_hue = wrap band)
//   min_sat       saturation lower bound, inclusive
//   min_val       value lower bound, inclusive
//   frame_ack     consumer releases a completed frame
//   rd_row        row select; rd_data follows one cycle later
//   rd_data       mask row, bit c = column c; rows >= LENGTH read as 0
//   frame_ready   a full frame is stored
//   pix_valid     one-cycle pulse per classified pixel
//   pix_mask      mask bit of the last classified pixel
//   busy          receiving a frame
//   sync_err      sticky: a partial pixel was dropped by timeout
//   overflow_err  sticky: a Pi clock edge arrived while the frame was full
// -----------------------------------------------------------------------------
module hsv_frame_receiver #(
  parameter int LENGTH      = 30,
  parameter int WIDTH       = 30,
  parameter int CHAN_BITS   = 8,
  parameter int SYNC_STAGES = 2,
  parameter int DEBOUNCE    = 4,
  parameter int TIMEOUT     = 4096,
  localparam int ROW_BITS   = (LENGTH > 1) ? $clog2(LENGTH) : 1
) (
  input  logic                 fpga_clk,
  input  logic                 rst,
  input  logic                 pi_clk,
  input  logic                 data_in,
  input  logic                 write_enable,
  input  logic [CHAN_BITS-1:0] min_hue,
  input  logic [CHAN_BITS-1:0] max_hue,
  input  logic [CHAN_BITS-1:0] min_sat,
  input  logic [CHAN_BITS-1:0] min_val,
  input  logic                 frame_ack,
  input  logic [ROW_BITS-1:0]  rd_row,
  output logic [WIDTH-1:0]     rd_data,
  output logic                 frame_ready,
  output logic                 pix_valid,
  output logic                 pix_mask,
  output logic                 busy,
  output logic                 sync_err,
  output logic                 overflow_err
);

  localparam int PIX_BITS = 3 * CHAN_BITS;
  localparam int COL_BITS = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int CNT_BITS = $clog2(PIX_BITS + 1);
  localparam int DB_BITS  = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
  localparam int TO_BITS  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [ROW_BITS:0]   ROWS_EXT = (ROW_BITS + 1)'(LENGTH);
  localparam logic [ROW_BITS-1:0] LAST_ROW = ROW_BITS'(LENGTH - 1);
  localparam logic [COL_BITS-1:0] LAST_COL = COL_BITS'(WIDTH - 1);
  localparam logic [CNT_BITS-1:0] PIX_CNT  = CNT_BITS'(PIX_BITS);
  localparam logic [DB_BITS-1:0]  DB_LAST  = DB_BITS'(DEBOUNCE - 1);
  localparam logic [TO_BITS-1:0]  TO_LAST  = TO_BITS'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, RECV, FULL} state_t;

  // ---------------------------------------------------------------------------
  // Input conditioning
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] clk_sync, data_sync, we_sync;
  logic                   clk_s, data_s, we_s;

  // NOTE: sequential state is always assigned with <= so every flop samples
  // the pre-edge value of its neighbours; blocking assignments here would
  // collapse the synchroniser chain into a single flop.
  always_ff @(posedge fpga_clk or posedge rst) begin
    if (rst) begin
      clk_sync  <= '0;
      data_sync <= '0;
      we_sync   <= '0;
    end else begin
      clk_sync  <= {clk_sync[SYNC_STAGES-2:0], pi_clk};
      data_sync <= {data_sync[SYNC_STAGES-2:0], data_in};
      we_sync   <= {we_sync[SYNC_STAGES-2:0], write_enable};
    end
  end

  assign clk_s  = clk_sync[SYNC_STAGES-1];
  assign data_s = data_sync[SYNC_STAGES-1];
  assign we_s   = we_sync[SYNC_STAGES-1];

  // The filtered Pi clock only follows the synced level after DEBOUNCE
  // consecutive disagreeing samples, so short glitches never reach the FSM.
  logic               pi_filt;
  logic [DB_BITS-1:0] db_cnt;
  logic               strobe;

  always_ff @(posedge fpga_clk or posedge rst) begin
    if (rst) begin
      pi_filt <= 1'b0;
      db_cnt  <= '0;
      strobe  <= 1'b0;
    end else if (clk_s != pi_filt) begin
      if (db_cnt == DB_LAST) begin
        pi_filt <= clk_s;
        db_cnt  <= '0;
        strobe  <= clk_s;  // only the rising edge of the filtered level
      end else begin
        db_cnt  <= db_cnt + DB_BITS'(1);
        strobe  <= 1'b0;
      end
    end else begin
      db_cnt <= '0;
      strobe <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Classification of the assembled pixel
  // ---------------------------------------------------------------------------
  logic [PIX_BITS-1:0]  shift_reg;
  logic [CHAN_BITS-1:0] hue, sat, val;
  logic                 hue_ok, mask;

  assign hue = shift_reg[CHAN_BITS-1:0];
  assign sat = shift_reg[2*CHAN_BITS-1:CHAN_BITS];
  assign val = shift_reg[3*CHAN_BITS-1:2*CHAN_BITS];

  // min_hue > max_hue selects a band that wraps through zero (red hues).
  assign hue_ok = (min_hue <= max_hue) ? ((hue >= min_hue) && (hue <= max_hue))
                                       : ((hue >= min_hue) || (hue <= max_hue));
  assign mask   = hue_ok && (sat >= min_sat) && (val >= min_val);

  // ---------------------------------------------------------------------------
  // Receive FSM, frame buffer and readout
  // ---------------------------------------------------------------------------
  state_t              state;
  logic [ROW_BITS-1:0] row;
  logic [COL_BITS-1:0] col;
  logic [CNT_BITS-1:0] bit_cnt;
  logic [TO_BITS-1:0]  to_cnt;
  logic [WIDTH-1:0]    frame [LENGTH];

  always_ff @(posedge fpga_clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      row          <= '0;
      col          <= '0;
      bit_cnt      <= '0;
      to_cnt       <= '0;
      shift_reg    <= '0;
      rd_data      <= '0;
      frame_ready  <= 1'b0;
      pix_valid    <= 1'b0;
      pix_mask     <= 1'b0;
      busy         <= 1'b0;
      sync_err     <= 1'b0;
      overflow_err <= 1'b0;
      // NOTE: the buffer is cleared on reset so a consumer can never read a
      // mask left over from before the reset; this keeps it in flops rather
      // than a RAM macro, which is acceptable at up to 64x64 bits.
      for (int r = 0; r < LENGTH; r++) frame[r] <= '0;
    end else begin
      pix_valid <= 1'b0;
      // Read sees the pre-write row when it coincides with a pixel write.
      rd_data   <= ({1'b0, rd_row} < ROWS_EXT) ? frame[rd_row] : '0;

      case (state)
        IDLE: begin
          if (we_s) begin
            state <= RECV;
            busy  <= 1'b1;
          end
        end

        RECV: begin
          if (bit_cnt == PIX_CNT) begin
            // Pixel complete: commit the mask the cycle after the last bit.
            frame[row][col] <= mask;
            pix_valid       <= 1'b1;
            pix_mask        <= mask;
            bit_cnt         <= '0;
            shift_reg       <= '0;
            to_cnt          <= '0;
            if (col == LAST_COL) begin
              col <= '0;
              if (row == LAST_ROW) begin
                row         <= '0;
                state       <= FULL;
                busy        <= 1'b0;
                frame_ready <= 1'b1;
              end else begin
                row <= row + ROW_BITS'(1);
              end
            end else begin
              col <= col + COL_BITS'(1);
            end
          end else if (strobe) begin
            to_cnt <= '0;
            if (we_s) begin
              shift_reg <= {data_s, shift_reg[PIX_BITS-1:1]};
              bit_cnt   <= bit_cnt + CNT_BITS'(1);
            end
          end else if (bit_cnt != '0) begin
            if (to_cnt == TO_LAST) begin
              // Pi lost bit alignment: drop the partial pixel, keep position.
              bit_cnt   <= '0;
              shift_reg <= '0;
              to_cnt    <= '0;
              sync_err  <= 1'b1;
            end else begin
              to_cnt <= to_cnt + TO_BITS'(1);
            end
          end else begin
            to_cnt <= '0;
          end
        end

        FULL: begin
          if (frame_ack) begin
            state        <= IDLE;
            row          <= '0;
            col          <= '0;
            bit_cnt      <= '0;
            frame_ready  <= 1'b0;
            sync_err     <= 1'b0;
            overflow_err <= 1'b0;
          end else if (strobe) begin
            overflow_err <= 1'b1;
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hsv_frame_receiver.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_hsv_frame_receiver
//
// Directed bench for hsv_frame_receiver with a 2x2 frame. Pixels are shifted
// in LSB first with a 40-cycle Pi clock; expected masks are computed by a
// small classifier model, queued when a pixel is sent and popped when the DUT
// pulses pix_valid. A frame model tracks the expected buffer for readout.
// -----------------------------------------------------------------------------
module tb_hsv_frame_receiver;

  localparam int LENGTH      = 2;
  localparam int WIDTH       = 2;
  localparam int CHAN_BITS   = 8;
  localparam int SYNC_STAGES = 2;
  localparam int DEBOUNCE    = 2;
  localparam int TIMEOUT     = 64;
  localparam int HALF_BIT    = 20;

  logic                 fpga_clk = 1'b0;
  logic                 rst;
  logic                 pi_clk;
  logic                 data_in;
  logic                 write_enable;
  logic [CHAN_BITS-1:0] min_hue, max_hue, min_sat, min_val;
  logic                 frame_ack;
  logic [0:0]           rd_row;
  logic [WIDTH-1:0]     rd_data;
  logic                 frame_ready, pix_valid, pix_mask, busy;
  logic                 sync_err, overflow_err;

  hsv_frame_receiver #(
    .LENGTH      (LENGTH),
    .WIDTH       (WIDTH),
    .CHAN_BITS   (CHAN_BITS),
    .SYNC_STAGES (SYNC_STAGES),
    .DEBOUNCE    (DEBOUNCE),
    .TIMEOUT     (TIMEOUT)
  ) dut (
    .fpga_clk     (fpga_clk),
    .rst          (rst),
    .pi_clk       (pi_clk),
    .data_in      (data_in),
    .write_enable (write_enable),
    .min_hue      (min_hue),
    .max_hue      (max_hue),
    .min_sat      (min_sat),
    .min_val      (min_val),
    .frame_ack    (frame_ack),
    .rd_row       (rd_row),
    .rd_data      (rd_data),
    .frame_ready  (frame_ready),
    .pix_valid    (pix_valid),
    .pix_mask     (pix_mask),
    .busy         (busy),
    .sync_err     (sync_err),
    .overflow_err (overflow_err)
  );

  always #5 fpga_clk = ~fpga_clk;

  int         vectors     = 0;
  int         miscompares = 0;
  logic       exp_q [$];
  logic [WIDTH-1:0] exp_frame [LENGTH];
  int         exp_row, exp_col;
  int         pv_count;
  logic       pv_mask, pv_ready;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic classify(input logic [7:0] h, s, v);
    logic in_band;
    if (min_hue <= max_hue) in_band = (h >= min_hue) && (h <= max_hue);
    else                    in_band = (h >= min_hue) || (h <= max_hue);
    return in_band && (s >= min_sat) && (v >= min_val);
  endfunction

  task automatic tick();
    @(negedge fpga_clk);
  endtask

  task automatic clear_model();
    exp_row = 0;
    exp_col = 0;
    for (int r = 0; r < LENGTH; r++) exp_frame[r] = '0;
  endtask

  // One Pi bit: data set with the falling Pi clock, held through the high
  // phase. Optional 3 ns pi_clk glitch straddling an fpga_clk rising edge.
  task automatic send_bit(input logic b, input bit glitch);
    pi_clk  = 1'b0;
    data_in = b;
    repeat (HALF_BIT / 2) tick();
    if (glitch) begin
      #3 pi_clk = 1'b1;
      #3 pi_clk = 1'b0;
    end
    repeat (HALF_BIT - HALF_BIT / 2) tick();
    pi_clk = 1'b1;
    for (int i = 0; i < HALF_BIT; i++) begin
      tick();
      if (pix_valid) begin
        pv_count++;
        pv_mask  = pix_mask;
        pv_ready = frame_ready;
      end
    end
  endtask

  task automatic send_pixel(input logic [7:0] h, s, v, input int glitch_at);
    logic [23:0] word;
    logic        exp_mask;
    logic        exp_ready;
    word = {v, s, h};
    exp_q.push_back(classify(h, s, v));
    pv_count = 0;
    for (int k = 0; k < 24; k++) send_bit(word[k], k == glitch_at);
    pi_clk = 1'b0;
    check("pix_count", pv_count, 1);
    exp_mask  = exp_q.pop_front();
    exp_ready = (exp_row == LENGTH - 1) && (exp_col == WIDTH - 1);
    check("pix_mask", 32'(pv_mask), 32'(exp_mask));
    check("frame_ready_at_pulse", 32'(pv_ready), 32'(exp_ready));
    exp_frame[exp_row][exp_col] = exp_mask;
    if (exp_col == WIDTH - 1) begin
      exp_col = 0;
      exp_row = (exp_row == LENGTH - 1) ? 0 : exp_row + 1;
    end else begin
      exp_col++;
    end
  endtask

  task automatic check_row(input int r);
    rd_row = 1'(r);
    tick();
    check("rd_data", 32'(rd_data), 32'(exp_frame[r]));
  endtask

  task automatic release_frame();
    write_enable = 1'b0;
    repeat (4) tick();
    frame_ack = 1'b1;
    tick();
    frame_ack = 1'b0;
    tick();
    clear_model_pos();
  endtask

  task automatic clear_model_pos();
    exp_row = 0;
    exp_col = 0;
  endtask

  initial begin
    rst = 1'b1; pi_clk = 1'b0; data_in = 1'b0; write_enable = 1'b0;
    frame_ack = 1'b0; rd_row = '0;
    min_hue = 8'd10; max_hue = 8'd50; min_sat = 8'd40; min_val = 8'd40;
    clear_model();
    repeat (3) tick();

    // Reset state
    check("rst_frame_ready", 32'(frame_ready), 0);
    check("rst_pix_valid", 32'(pix_valid), 0);
    check("rst_pix_mask", 32'(pix_mask), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_sync_err", 32'(sync_err), 0);
    check("rst_overflow_err", 32'(overflow_err), 0);
    check("rst_rd_data", 32'(rd_data), 0);
    rst = 1'b0;
    tick();

    // Normal band: masks 1,0,0,1; frame_ready with the 4th pulse
    write_enable = 1'b1;
    repeat (5) tick();
    check("busy_recv", 32'(busy), 1);
    send_pixel(8'd30, 8'd100, 8'd100, -1);
    send_pixel(8'd60, 8'd100, 8'd100, -1);
    send_pixel(8'd30, 8'd20,  8'd100, -1);
    send_pixel(8'd30, 8'd100, 8'd100, -1);
    check("frame_ready_full", 32'(frame_ready), 1);
    check("busy_full", 32'(busy), 0);
    check_row(0);
    check_row(1);

    // Overflow: a bit while full, then release
    send_bit(1'b1, 1'b0);
    pi_clk = 1'b0;
    repeat (5) tick();
    check("overflow_set", 32'(overflow_err), 1);
    check("overflow_frame_ready", 32'(frame_ready), 1);
    release_frame();
    check("ack_frame_ready", 32'(frame_ready), 0);
    check("ack_overflow_err", 32'(overflow_err), 0);
    check("ack_sync_err", 32'(sync_err), 0);
    check("ack_idle", 32'(busy), 0);
    check_row(0);  // contents retained after release

    // Wrap-around hue band; glitch inside the 4th pixel must not add a bit
    min_hue = 8'd200; max_hue = 8'd20;
    write_enable = 1'b1;
    repeat (5) tick();
    send_pixel(8'd250, 8'd100, 8'd100, -1);
    send_pixel(8'd5,   8'd100, 8'd100, -1);
    send_pixel(8'd100, 8'd100, 8'd100, -1);
    send_pixel(8'd30,  8'd100, 8'd100, 12);
    repeat (10) tick();
    check("glitch_no_overflow", 32'(overflow_err), 0);
    check("glitch_frame_ready", 32'(frame_ready), 1);
    check_row(0);
    check_row(1);
    release_frame();

    // Timeout: 10 bits, idle, then a full pixel lands at (0,0)
    min_hue = 8'd10; max_hue = 8'd50;
    write_enable = 1'b1;
    repeat (5) tick();
    pv_count = 0;
    for (int k = 0; k < 10; k++) send_bit(k[0], 1'b0);
    pi_clk = 1'b0;
    check("partial_no_pulse", pv_count, 0);
    repeat (100) tick();
    check("timeout_sync_err", 32'(sync_err), 1);
    send_pixel(8'd30, 8'd100, 8'd100, -1);
    send_pixel(8'd60, 8'd100, 8'd100, -1);
    check("sync_err_sticky", 32'(sync_err), 1);
    check_row(0);

    // Reset mid-frame: buffer cleared, next frame starts at (0,0)
    rst = 1'b1;
    repeat (3) tick();
    check("midrst_sync_err", 32'(sync_err), 0);
    check("midrst_busy", 32'(busy), 0);
    rst = 1'b0;
    clear_model();
    check_row(0);
    repeat (5) tick();
    send_pixel(8'd30, 8'd100, 8'd100, -1);
    send_pixel(8'd60, 8'd100, 8'd100, -1);
    send_pixel(8'd30, 8'd20,  8'd100, -1);
    send_pixel(8'd30, 8'd100, 8'd20,  -1);
    check("post_rst_frame_ready", 32'(frame_ready), 1);
    check_row(0);
    check_row(1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
